// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use stalls, branch flushes, instruction-memory wait
// handling with a post-reset boot hold, operand forwarding and perf counters.
module hazard_ctrl #(
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             imem_ready,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } state_t;

  localparam int BW = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES + 1);
  localparam logic [BW-1:0] BOOT_LOAD = BW'(BOOT_CYCLES);
  localparam state_t RST_STATE = (BOOT_CYCLES == 0) ? FETCH : BOOT;

  state_t          state;
  logic [BW-1:0]   boot_cnt;
  logic            lw_stall;

  assign lw_stall  = ResultSrcE0 && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));
  assign dbg_state = state;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wm,
                                         input logic [4:0] rdm, input logic ww,
                                         input logic [4:0] rdw);
    if (wm && (rdm != 5'd0) && (rdm == rs))      fwd_sel = 2'b10;
    else if (ww && (rdw != 5'd0) && (rdw == rs)) fwd_sel = 2'b01;
    else                                         fwd_sel = 2'b00;
  endfunction

  assign ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
  assign ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);

  always_comb begin
    StallF = 1'b1;
    StallD = 1'b0;
    FlushD = 1'b1;
    FlushE = 1'b1;
    if (rst || state == BOOT) begin
      StallF = 1'b1;
      StallD = 1'b0;
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (state == DROP) begin
      // The in-flight fetch is stale; ID keeps receiving bubbles until it returns.
      StallF = !PCSrcE;
      StallD = 1'b0;
      FlushD = 1'b1;
      FlushE = PCSrcE ? 1'b1 : lw_stall;
    end else if (state == FETCH) begin
      if (PCSrcE) begin
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushD = 1'b0;
        FlushE = 1'b1;
      end else if (!imem_ready) begin
        StallF = 1'b1;
        StallD = 1'b0;
        FlushD = 1'b1;
        FlushE = 1'b0;
      end else begin
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RST_STATE;
      boot_cnt  <= BOOT_LOAD;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        BOOT: begin
          if (boot_cnt <= BW'(1)) state <= FETCH;
          if (boot_cnt != '0) boot_cnt <= boot_cnt - BW'(1);
        end
        FETCH: if (PCSrcE && !imem_ready) state <= DROP;
        DROP:  if (!PCSrcE && imem_ready) state <= FETCH;
        default: state <= FETCH;
      endcase
      // Counters saturate so long runs never wrap back to small values.
      if (state != BOOT) begin
        if (StallF && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
        if (PCSrcE && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic, checked every
// cycle against a behavioural model of the fetch/boot/stale-fetch rules.
module tb_hazard_ctrl;

  localparam int BOOT_CYCLES = 2;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, imem_ready;
  logic             StallF, StallD, FlushD, FlushE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [1:0]       dbg_state;

  hazard_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .imem_ready(imem_ready),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // scoreboard: {StallF,StallD,FlushD,FlushE,ForwardAE,ForwardBE}
  logic [7:0] exp_q[$];

  // model state: cycles of boot hold left, stale fetch outstanding, counter totals
  int m_boot_left;
  bit m_stale;
  int m_stall;
  int m_flush;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs)      return 2'b10;
    else if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    else                                         return 2'b00;
  endfunction

  task automatic model_predict();
    bit lw;
    logic [3:0] ctl;
    lw = ResultSrcE0 && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
    if (rst || m_boot_left > 0) ctl = 4'b1011;
    else if (m_stale)           ctl = PCSrcE ? 4'b0011 : {3'b101, lw};
    else if (PCSrcE)            ctl = 4'b0011;
    else if (lw)                ctl = 4'b1101;
    else if (!imem_ready)       ctl = 4'b1010;
    else                        ctl = 4'b0000;
    exp_q.push_back({ctl, ref_fwd(Rs1E), ref_fwd(Rs2E)});
  endtask

  task automatic model_update(input bit exp_stallf);
    if (rst) begin
      m_boot_left = BOOT_CYCLES;
      m_stale     = 0;
      m_stall     = 0;
      m_flush     = 0;
    end else if (m_boot_left > 0) begin
      m_boot_left--;
    end else begin
      if (exp_stallf && m_stall < CNT_MAX) m_stall++;
      if (PCSrcE && m_flush < CNT_MAX)     m_flush++;
      if (m_stale) begin
        if (!PCSrcE && imem_ready) m_stale = 0;
      end else if (PCSrcE && !imem_ready) begin
        m_stale = 1;
      end
    end
  endtask

  // one clock: compare at the falling edge, advance the model at the rising edge
  task automatic cycle();
    logic [7:0] e;
    @(negedge clk);
    model_predict();
    e = exp_q.pop_front();
    check("ctl", {StallF, StallD, FlushD, FlushE}, e[7:4]);
    check("fwd", {ForwardAE, ForwardBE}, e[3:0]);
    check("stall_cnt", stall_cnt, m_stall);
    check("flush_cnt", flush_cnt, m_flush);
    @(posedge clk);
    model_update(e[7]);
    #1;
  endtask

  // driver tasks
  task automatic drive_idle();
    rst = 0; Rs1D = 1; Rs2D = 2; Rs1E = 3; Rs2E = 4; RdE = 9; RdM = 10; RdW = 11;
    ResultSrcE0 = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0; imem_ready = 1;
  endtask

  task automatic drive_random();
    rst         = ($urandom_range(0, 49) == 0);
    Rs1D        = 5'($urandom_range(0, 3));
    Rs2D        = 5'($urandom_range(0, 3));
    Rs1E        = 5'($urandom_range(0, 3));
    Rs2E        = 5'($urandom_range(0, 3));
    RdE         = 5'($urandom_range(0, 3));
    RdM         = 5'($urandom_range(0, 3));
    RdW         = 5'($urandom_range(0, 3));
    ResultSrcE0 = ($urandom_range(0, 2) == 0);
    PCSrcE      = ($urandom_range(0, 4) == 0);
    RegWriteM   = 1'($urandom_range(0, 1));
    RegWriteW   = 1'($urandom_range(0, 1));
    imem_ready  = ($urandom_range(0, 2) != 0);
  endtask

  task automatic do_reset();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
  endtask

  initial begin
    drive_idle();
    rst = 1;
    m_boot_left = BOOT_CYCLES; m_stale = 0; m_stall = 0; m_flush = 0;
    @(posedge clk); #1;

    // reset held, then boot hold with a branch that must be ignored
    do_reset();
    PCSrcE = 1;
    cycle();
    PCSrcE = 0;
    repeat (3) cycle();
    check("boot_stall_cnt", stall_cnt, 0);

    // load-use hazard, then same load writing x0
    RdE = 5; ResultSrcE0 = 1; Rs2D = 5;
    cycle();
    RdE = 0;
    cycle();
    drive_idle();
    check("lw_stall_cnt", stall_cnt, 1);

    // instruction memory busy for three cycles
    imem_ready = 0;
    repeat (3) cycle();
    imem_ready = 1;
    cycle();
    check("busy_stall_cnt", stall_cnt, 4);

    // branch with fetch outstanding, stale response two cycles later
    PCSrcE = 1; imem_ready = 0;
    cycle();
    PCSrcE = 0;
    cycle();
    imem_ready = 1;
    cycle();
    imem_ready = 0;
    cycle();
    imem_ready = 1;
    cycle();
    check("stale_flush_cnt", flush_cnt, 1);

    // branch during a stale wait, then a load-use inside the wait
    PCSrcE = 1; imem_ready = 0;
    cycle();
    PCSrcE = 1; imem_ready = 1;
    cycle();
    PCSrcE = 0; imem_ready = 0; RdE = 2; ResultSrcE0 = 1;
    cycle();
    drive_idle();
    cycle();

    // branch and load-use together
    PCSrcE = 1; RdE = 1; ResultSrcE0 = 1;
    cycle();
    drive_idle();

    // forwarding priority
    RdM = 7; RdW = 7; Rs1E = 7; Rs2E = 7; RegWriteM = 1; RegWriteW = 1;
    cycle();
    check("fwdA_mem", ForwardAE, 2'b10);
    RegWriteM = 0;
    cycle();
    check("fwdA_wb", ForwardAE, 2'b01);
    Rs1E = 0;
    cycle();
    check("fwdA_rf", ForwardAE, 2'b00);
    drive_idle();

    // saturate the stall counter
    imem_ready = 0;
    repeat (CNT_MAX + 4) cycle();
    check("stall_sat", stall_cnt, CNT_MAX);
    imem_ready = 1;

    // reset in the middle of a stale wait leaves nothing behind
    PCSrcE = 1; imem_ready = 0;
    cycle();
    PCSrcE = 0;
    do_reset();
    imem_ready = 1;
    repeat (4) cycle();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive_random();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter BOOT_CYCLES, default 2: number of post-reset cycles the front end is held.
REQ-002 SHALL have parameter CNT_W, default 16: width of each performance counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port Rs1D, Rs2D, input, 5 each: source registers of the instruction in ID.
REQ-006 SHALL have port Rs1E, Rs2E, RdE, input, 5 each: source and destination registers of the instruction in EX.
REQ-007 SHALL have port ResultSrcE0, input, 1: EX instruction is a load.
REQ-008 SHALL have port PCSrcE, input, 1: branch/jump taken in EX; PC redirects this cycle.
REQ-009 SHALL have port RdM, RdW, input, 5 each, and RegWriteM, RegWriteW, input, 1 each: MEM/WB writeback info.
REQ-010 SHALL have port imem_ready, input, 1: InstrF is valid for the PC that was fetching.
REQ-011 SHALL have port StallF, output, 1: hold PC; StallD, output, 1: IF/ID ld = !StallD.
REQ-012 SHALL have port FlushD, output, 1, and FlushE, output, 1: clear the IF/ID and ID/EX registers.
REQ-013 SHALL have port ForwardAE, ForwardBE, output, 2 each: 00 register file, 10 MEM result, 01 WB result.
REQ-014 SHALL have port stall_cnt, flush_cnt, output, CNT_W each: performance counters.

Function
REQ-015 SHALL define lwStall = ResultSrcE0 & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
REQ-016 SHALL implement FSM states BOOT, FETCH and DROP, with a BOOT down-counter loaded with BOOT_CYCLES.
REQ-017 In BOOT, SHALL drive StallF=1, StallD=0, FlushD=1, FlushE=1; PCSrcE and lwStall are ignored.
REQ-018 SHALL go BOOT->FETCH after BOOT_CYCLES cycles; BOOT_CYCLES=0 goes directly to FETCH.
REQ-019 In FETCH with PCSrcE=1, SHALL drive StallF=0, StallD=0, FlushD=1, FlushE=1; this overrides lwStall.
REQ-020 In FETCH with PCSrcE=1 and imem_ready=0, SHALL go to DROP next cycle, because the outstanding fetch is stale.
REQ-021 In FETCH with PCSrcE=0 and lwStall=1, SHALL drive StallF=1, StallD=1, FlushD=0, FlushE=1, independent of imem_ready.
REQ-022 In FETCH with PCSrcE=0, lwStall=0 and imem_ready=0, SHALL drive StallF=1, StallD=0, FlushD=1, FlushE=0 (bubble into ID).
REQ-023 In FETCH with PCSrcE=0, lwStall=0 and imem_ready=1, SHALL drive all stall and flush outputs to 0.
REQ-024 In DROP, SHALL drive StallF=1, StallD=0, FlushD=1, FlushE=lwStall; the returning response is discarded.
REQ-025 In DROP with imem_ready=1 and PCSrcE=0, SHALL go to FETCH next cycle; StallF stays 1 that cycle.
REQ-026 In DROP with PCSrcE=1, SHALL drive StallF=0, FlushD=1, FlushE=1 and remain in DROP, even if imem_ready=1.
REQ-027 SHALL set ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E, else 01 if RegWriteW & RdW!=0 & RdW==Rs1E, else 00.
REQ-028 SHALL compute ForwardBE the same way using Rs2E; MEM has priority over WB.
REQ-029 SHALL make all stall, flush and forward outputs combinational from the current state and inputs.
REQ-030 SHALL increment stall_cnt on every cycle with StallF=1, outside BOOT, saturating at all-ones.
REQ-031 SHALL increment flush_cnt on every cycle with PCSrcE=1, outside BOOT, saturating at all-ones.

Reset
REQ-032 When rst=1 at a clock edge, SHALL enter BOOT, reload the BOOT counter, and clear stall_cnt and flush_cnt to 0.
REQ-033 While rst=1, SHALL drive StallF=1, StallD=0, FlushD=1, FlushE=1; ForwardAE/BE follow REQ-027/028.
REQ-034 Reset asserted mid-DROP or mid-stall SHALL abandon the pending state with no residual effect after BOOT.

Verification
REQ-035 Release rst with BOOT_CYCLES=2 and imem_ready=1 -> StallF=FlushD=FlushE=1 for exactly 2 cycles, then all 0; counters stay 0.
REQ-036 Load with RdE=5, ResultSrcE0=1, Rs2D=5 -> one cycle of StallF=StallD=FlushE=1, FlushD=0; stall_cnt +1; RdE=0 -> no stall.
REQ-037 Hold imem_ready=0 for 3 cycles in FETCH -> StallF=1, FlushD=1, StallD=0 each cycle; stall_cnt +3.
REQ-038 Pulse PCSrcE while imem_ready=0, stale response arrives 2 cycles later -> StallF 0,1,1,1; state FETCH after the response; FlushD=1 throughout; flush_cnt +1.
REQ-039 PCSrcE and lwStall in the same FETCH cycle -> StallF=0, StallD=0, FlushD=1, FlushE=1.
REQ-040 RdM=RdW=Rs1E=7, RegWriteM=RegWriteW=1 -> ForwardAE=10; RegWriteM=0 -> 01; Rs1E=0 -> 00; drive stall_cnt to all-ones -> holds.
